scroll_display_mux: RTL and testbench
=====================================

Name: scroll_display_mux

Overview:
- Parametrised scrolling multiplexed 7-segment driver, the successor to the fixed two-frame 4-digit display.
- Holds a run-time writable message buffer of MSG_LEN segment codes.
- Shows a DIGITS-wide window of the buffer, time-multiplexed across the digit selects.
- Scrolls the window left or right at a programmable step rate. Sits between board-level control logic and the 7-segment pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8)
- MSG_LEN, 16, buffer depth in characters (DIGITS..256)
- AW, 4, buffer address width; must equal clog2(MSG_LEN)
- REFRESH_DIV, 25000, fastclk cycles per digit slot (4 kHz slot rate at 100 MHz)
- STEP_DIV, 100000000, fastclk cycles per scroll step (1 s at 100 MHz)

Ports:
- fastclk, in, 1: single system clock
- resetin, in, 1: asynchronous, active-low reset
- wr_en, in, 1: buffer write strobe
- wr_addr, in, AW: buffer write index
- wr_data, in, 8: segment code {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active high
- len_we, in, 1: message-length write strobe
- len_val, in, AW+1: new active message length
- scroll_en, in, 1: 1 = scrolling, 0 = window frozen
- dir, in, 1: 0 = scroll left (offset increments), 1 = scroll right (offset decrements)
- select, out, DIGITS: one-hot active-high digit enable; MSB = leftmost digit (digit 0)
- hex_display, out, 8: segment code for the selected digit
- window_pos, out, AW: current window offset
- wrap_pulse, out, 1: one-cycle pulse when the offset wraps

Behaviour:
- Reset (resetin=0, async), all state cleared:
  - buffer all 8'h00 (blank); msg_len=MSG_LEN
  - offset=0; digit_idx=0; both prescalers 0
  - select={1,0..0}; hex_display=0; window_pos=0; wrap_pulse=0
- Reset asserted mid-scroll aborts immediately. No buffer content survives reset.
- Buffer write: wr_en with wr_addr<MSG_LEN writes wr_data at the next edge. wr_addr>=MSG_LEN is ignored.
- Length write (len_we):
  - len_val=0 is ignored.
  - len_val>MSG_LEN is clamped to MSG_LEN.
  - If offset>=new length, offset becomes 0 in the same edge; no wrap_pulse.
- Refresh prescaler: counts 0..REFRESH_DIV-1 continuously. At the terminal count, digit_idx advances modulo DIGITS (0→1→…→DIGITS-1→0).
- Display outputs are registered every cycle from current state:
  - select = one-hot with bit (DIGITS-1-digit_idx) set
  - hex_display = buf[(offset+digit_idx) mod msg_len]
  - select and hex_display change on the same edge (no ghosting).
  - A buffer write is visible on hex_display 2 cycles after wr_en when that character is selected.
- Window wraps modulo msg_len. When msg_len<DIGITS the message repeats across digits.
- Step prescaler:
  - Counts 0..STEP_DIV-1 only while scroll_en=1; held at 0 while scroll_en=0.
  - First step occurs STEP_DIV cycles after scroll_en rises.
  - At the terminal count: dir=0 → offset=(offset+1) mod msg_len; dir=1 → offset=(offset-1) mod msg_len.
- wrap_pulse=1 for exactly one cycle, on the edge where:
  - offset goes msg_len-1→0 (dir=0), or
  - offset goes 0→msg_len-1 (dir=1).
  - With msg_len=1 the offset stays 0 and wrap_pulse fires every step.
- Simultaneous events:
  - len_we and a step terminal count on the same edge: len_we wins; that step is discarded and the prescaler restarts at 0.
  - wr_en and a step on the same edge: both take effect.
  - A dir change takes effect at the next step.
- window_pos mirrors offset (registered, same cycle as offset update).

Optional Feature:
- Macro BLINK_EN.
- When defined:
  - Adds input port blink (1 bit) and parameter BLINK_DIV (default 50000000).
  - A blink-phase flop toggles every BLINK_DIV cycles while blink=1. It is forced to phase ON (0) while blink=0 and at reset.
  - During phase OFF, hex_display is forced to 8'h00; select keeps scanning and scrolling continues.
- When undefined: no blink port or logic; hex_display is never forced.

Test Plan (DIGITS=4, MSG_LEN=8, AW=3, REFRESH_DIV=4, STEP_DIV=64):
- Reset then release, no writes → select 4'b1000 after reset, then 0100, 0010, 0001 every 4 cycles. hex_display stays 8'h00; window_pos=0.
- Write buf[0..7]=8'hFC,60,DA,F2,66,B6,BE,E0; scroll_en=0 → slot digit0 shows FC, digit3 shows F2; no offset change over 1000 cycles.
- scroll_en=1, dir=0 → window_pos 1 after 64 cycles (digit0=60, digit3=66). After 8 steps window_pos=0 with a single-cycle wrap_pulse. With offset=6, digit2=FC (wrap).
- dir=1 from offset 0 → next step window_pos=7 with wrap_pulse; digit0=E0, digit1=FC.
- At offset 5, len_we with len_val=3 → offset 0, no wrap_pulse. len_val=0 leaves length unchanged. len_val=12 clamps to 8. len_we coinciding with a step terminal → no step that edge.
- Assert resetin mid-step (offset 4) → all outputs to reset values asynchronously; buffer reads 8'h00 after release. BLINK_EN build, blink=1, BLINK_DIV=16 → hex_display 0 for alternate 16-cycle windows while select scans.

Source files
------------

// File: rtl/scroll_display_mux_if.sv
// Control/display bundle between board logic and scroll_display_mux.
// Optional build macro BLINK_EN adds the blink request line.
interface scroll_display_mux_if #(
    parameter int DIGITS = 4,
    parameter int AW     = 4
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic              len_we;
    logic [AW:0]       len_val;
    logic              scroll_en;
    logic              dir;
`ifdef BLINK_EN
    logic              blink;
`endif
    logic [DIGITS-1:0] select;
    logic [7:0]        hex_display;
    logic [AW-1:0]     window_pos;
    logic              wrap_pulse;

    modport master (
        output wr_en, wr_addr, wr_data, len_we, len_val, scroll_en, dir,
`ifdef BLINK_EN
        output blink,
`endif
        input  select, hex_display, window_pos, wrap_pulse
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len_we, len_val, scroll_en, dir,
`ifdef BLINK_EN
        input  blink,
`endif
        output select, hex_display, window_pos, wrap_pulse
    );
endinterface

// File: rtl/scroll_display_mux.sv
// Scrolling multiplexed 7-segment driver over a writable MSG_LEN-character buffer.
// Optional build macro BLINK_EN adds a blink input that blanks hex_display on alternate BLINK_DIV windows.
module scroll_display_mux #(
    parameter int DIGITS      = 4,
    parameter int MSG_LEN     = 16,
    parameter int AW          = 4,
    parameter int REFRESH_DIV = 25000,
`ifdef BLINK_EN
    parameter int BLINK_DIV   = 50000000,
`endif
    parameter int STEP_DIV    = 100000000
) (
    input logic              fastclk,
    input logic              resetin,
    scroll_display_mux_if.slave dsp
);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [7:0]        mem_q [MSG_LEN];
    logic [AW:0]       len_q, len_d, len_new;
    logic [AW-1:0]     off_q, off_d;
    logic              wrap_q, wrap_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [SW-1:0]     stp_q, stp_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        hex_q, hex_d;
    logic [AW+1:0]     rd_idx;
    logic              addr_ok, len_hit, step_tc;

    generate
        if (MSG_LEN < (1 << AW)) begin : g_addr_chk
            assign addr_ok = ({1'b0, dsp.wr_addr} < (AW+1)'(MSG_LEN));
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        ref_d = ref_q + 1'b1;
        dig_d = dig_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    // A real length write takes priority over a coincident scroll step.
    always_comb begin
        len_new = (dsp.len_val > (AW+1)'(MSG_LEN)) ? (AW+1)'(MSG_LEN) : dsp.len_val;
        len_hit = dsp.len_we && (dsp.len_val != '0);
        step_tc = dsp.scroll_en && (stp_q == SW'(STEP_DIV - 1));
        stp_d   = (!dsp.scroll_en || step_tc) ? '0 : stp_q + 1'b1;
        len_d   = len_q;
        off_d   = off_q;
        wrap_d  = 1'b0;
        if (len_hit) begin
            len_d = len_new;
            if ({1'b0, off_q} >= len_new) off_d = '0;
        end else if (step_tc) begin
            if (!dsp.dir) begin
                if ({1'b0, off_q} == len_q - 1'b1) begin
                    off_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    off_d = off_q + 1'b1;
                end
            end else begin
                if (off_q == '0) begin
                    off_d  = AW'(len_q - 1'b1);
                    wrap_d = 1'b1;
                end else begin
                    off_d = off_q - 1'b1;
                end
            end
        end
    end

`ifdef BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bph_q, bph_d;

    always_comb begin
        bcnt_d = '0;
        bph_d  = 1'b0;
        if (dsp.blink) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
                bph_d  = bph_q;
            end
        end
    end

    always_ff @(posedge fastclk or negedge resetin) begin
        if (!resetin) begin
            bcnt_q <= '0;
            bph_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            bph_q  <= bph_d;
        end
    end
`endif

    // offset+digit can exceed len several times over when len < DIGITS.
    always_comb begin
        rd_idx = {2'b00, off_q} + (AW+2)'(dig_q);
        for (int unsigned k = 0; k < unsigned'(DIGITS); k++) begin
            if (rd_idx >= {1'b0, len_q}) rd_idx = rd_idx - {1'b0, len_q};
        end
        sel_d = {1'b1, {(DIGITS-1){1'b0}}} >> dig_q;
        hex_d = mem_q[rd_idx[AW-1:0]];
`ifdef BLINK_EN
        if (bph_q) hex_d = '0;
`endif
    end

    always_ff @(posedge fastclk or negedge resetin) begin
        if (!resetin) begin
            for (int unsigned i = 0; i < unsigned'(MSG_LEN); i++) mem_q[i] <= '0;
        end else if (dsp.wr_en && addr_ok) begin
            mem_q[dsp.wr_addr] <= dsp.wr_data;
        end
    end

    always_ff @(posedge fastclk or negedge resetin) begin
        if (!resetin) begin
            len_q  <= (AW+1)'(MSG_LEN);
            off_q  <= '0;
            wrap_q <= 1'b0;
            dig_q  <= '0;
            ref_q  <= '0;
            stp_q  <= '0;
            sel_q  <= {1'b1, {(DIGITS-1){1'b0}}};
            hex_q  <= '0;
        end else begin
            len_q  <= len_d;
            off_q  <= off_d;
            wrap_q <= wrap_d;
            dig_q  <= dig_d;
            ref_q  <= ref_d;
            stp_q  <= stp_d;
            sel_q  <= sel_d;
            hex_q  <= hex_d;
        end
    end

    assign dsp.select      = sel_q;
    assign dsp.hex_display = hex_q;
    assign dsp.window_pos  = off_q;
    assign dsp.wrap_pulse  = wrap_q;
endmodule

// File: tb/tb_scroll_display_mux.sv
// Directed bench for scroll_display_mux: DIGITS=4, MSG_LEN=8, AW=3, REFRESH_DIV=4, STEP_DIV=64.
module tb_scroll_display_mux;
    logic fastclk = 1'b0;
    logic resetin = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    int   s1, s8, s9, s11, s12, s15;
    logic [7:0] tab [8];

    always #5 fastclk = ~fastclk;

    scroll_display_mux_if #(.DIGITS(4), .AW(3)) dsp_if ();

    scroll_display_mux #(
        .DIGITS(4), .MSG_LEN(8), .AW(3), .REFRESH_DIV(4), .STEP_DIV(64)
    ) dut (
        .fastclk(fastclk),
        .resetin(resetin),
        .dsp(dsp_if)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fastclk);
            #1;
            cyc_n++;
        end
    endtask

    task automatic cyc_to(input int target);
        while (cyc_n < target) cyc(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until digit d is selected, then check its segment code.
    task automatic show(input int d, input logic [7:0] exp, input string tag);
        logic [3:0] tgt;
        tgt = 4'b1000 >> d;
        cyc(1);
        for (int i = 0; i < 20 && dsp_if.select !== tgt; i++) cyc(1);
        chk({tag, "_sel"}, dsp_if.select, tgt);
        chk(tag, dsp_if.hex_display, exp);
    endtask

    initial begin
        tab[0] = 8'hFC; tab[1] = 8'h60; tab[2] = 8'hDA; tab[3] = 8'hF2;
        tab[4] = 8'h66; tab[5] = 8'hB6; tab[6] = 8'hBE; tab[7] = 8'hE0;
        dsp_if.wr_en = 1'b0; dsp_if.wr_addr = '0; dsp_if.wr_data = '0;
        dsp_if.len_we = 1'b0; dsp_if.len_val = '0;
        dsp_if.scroll_en = 1'b0; dsp_if.dir = 1'b0;
`ifdef BLINK_EN
        dsp_if.blink = 1'b0;
`endif
        #22;
        chk("rst_sel", dsp_if.select, 4'b1000);
        chk("rst_hex", dsp_if.hex_display, 8'h00);
        chk("rst_pos", dsp_if.window_pos, 3'd0);
        chk("rst_wrap", dsp_if.wrap_pulse, 1'b0);
        resetin = 1'b1;

        // Scan order with an empty buffer
        cyc(4);  chk("scan_d0", dsp_if.select, 4'b1000);
        cyc(1);  chk("scan_d1", dsp_if.select, 4'b0100);
        cyc(4);  chk("scan_d2", dsp_if.select, 4'b0010);
        chk("scan_hex", dsp_if.hex_display, 8'h00);
        cyc(4);  chk("scan_d3", dsp_if.select, 4'b0001);
        cyc(4);  chk("scan_wrap", dsp_if.select, 4'b1000);
        chk("scan_pos", dsp_if.window_pos, 3'd0);

        // Load message, frozen window
        for (int i = 0; i < 8; i++) begin
            dsp_if.wr_en = 1'b1; dsp_if.wr_addr = 3'(i); dsp_if.wr_data = tab[i];
            cyc(1);
        end
        dsp_if.wr_en = 1'b0;
        show(0, 8'hFC, "frz_d0");
        show(3, 8'hF2, "frz_d3");
        show(1, 8'h60, "frz_d1");
        cyc(1000);
        chk("frz_pos", dsp_if.window_pos, 3'd0);
        chk("frz_wrap", dsp_if.wrap_pulse, 1'b0);

        // Scroll left
        dsp_if.scroll_en = 1'b1;
        s1 = cyc_n + 64;
        cyc_to(s1 - 1); chk("first_step_early", dsp_if.window_pos, 3'd0);
        cyc(1);         chk("first_step", dsp_if.window_pos, 3'd1);
        chk("first_step_wrap", dsp_if.wrap_pulse, 1'b0);
        show(0, 8'h60, "l1_d0");
        show(3, 8'h66, "l1_d3");
        cyc_to(s1 + 320); chk("l6_pos", dsp_if.window_pos, 3'd6);
        show(2, 8'hFC, "l6_d2");
        show(3, 8'h60, "l6_d3");
        s8 = s1 + 448;
        cyc_to(s8 - 1); chk("l7_pos", dsp_if.window_pos, 3'd7);
        chk("l7_wrap", dsp_if.wrap_pulse, 1'b0);
        cyc(1);         chk("l8_pos", dsp_if.window_pos, 3'd0);
        chk("l8_wrap", dsp_if.wrap_pulse, 1'b1);
        cyc(1);         chk("l8_wrap_fall", dsp_if.wrap_pulse, 1'b0);

        // Scroll right
        dsp_if.dir = 1'b1;
        s9 = s8 + 64;
        cyc_to(s9); chk("r_pos", dsp_if.window_pos, 3'd7);
        chk("r_wrap", dsp_if.wrap_pulse, 1'b1);
        show(0, 8'hE0, "r_d0");
        show(1, 8'hFC, "r_d1");
        s11 = s9 + 128;
        cyc_to(s11); chk("r5_pos", dsp_if.window_pos, 3'd5);

        // Length writes
        cyc_to(s11 + 10);
        dsp_if.len_we = 1'b1; dsp_if.len_val = 4'd3;
        cyc(1);
        dsp_if.len_we = 1'b0;
        chk("len3_pos", dsp_if.window_pos, 3'd0);
        chk("len3_wrap", dsp_if.wrap_pulse, 1'b0);
        show(3, 8'hFC, "len3_d3");
        s12 = s11 + 64;
        cyc_to(s12); chk("len3_rwrap_pos", dsp_if.window_pos, 3'd2);
        chk("len3_rwrap", dsp_if.wrap_pulse, 1'b1);
        cyc_to(s12 + 5);
        dsp_if.len_we = 1'b1; dsp_if.len_val = 4'd0;
        cyc(1);
        dsp_if.len_we = 1'b0;
        show(1, 8'hFC, "len0_d1");
        show(2, 8'h60, "len0_d2");
        cyc_to(s12 + 50);
        dsp_if.len_we = 1'b1; dsp_if.len_val = 4'd12;
        cyc(1);
        dsp_if.len_we = 1'b0;
        chk("len12_pos", dsp_if.window_pos, 3'd2);
        s15 = s12 + 192;
        cyc_to(s15); chk("len12_clamp_pos", dsp_if.window_pos, 3'd7);
        chk("len12_clamp_wrap", dsp_if.wrap_pulse, 1'b1);

        // Length write on a step terminal count
        cyc_to(s15 + 63);
        dsp_if.len_we = 1'b1; dsp_if.len_val = 4'd8;
        cyc(1);
        dsp_if.len_we = 1'b0;
        chk("coll_pos", dsp_if.window_pos, 3'd7);
        chk("coll_wrap", dsp_if.wrap_pulse, 1'b0);
        cyc_to(s15 + 127); chk("coll_restart_early", dsp_if.window_pos, 3'd7);
        cyc(1);            chk("coll_restart", dsp_if.window_pos, 3'd6);

        // Asynchronous reset mid-step
        cyc_to(s15 + 256); chk("pre_rst_pos", dsp_if.window_pos, 3'd4);
        cyc(30);
        dsp_if.scroll_en = 1'b0;
        resetin = 1'b0;
        #2;
        chk("arst_sel", dsp_if.select, 4'b1000);
        chk("arst_hex", dsp_if.hex_display, 8'h00);
        chk("arst_pos", dsp_if.window_pos, 3'd0);
        chk("arst_wrap", dsp_if.wrap_pulse, 1'b0);
        cyc(2);
        resetin = 1'b1;
        show(0, 8'h00, "post_rst_d0");
        show(3, 8'h00, "post_rst_d3");
        chk("post_rst_pos", dsp_if.window_pos, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
